// File: rtl/twofish_pkg.sv
// Shared constants for the Twofish h-function byte sequencer.
// TWOFISH_K3_EN: when defined, adds a leading L2 key stage (192-bit keys).
package twofish_pkg;

`ifdef TWOFISH_K3_EN
    localparam int unsigned NUM_STAGES = 4;
`else
    localparam int unsigned NUM_STAGES = 3;
`endif
    localparam int unsigned NUM_LANES  = 4;
    localparam int unsigned NUM_STEPS  = NUM_STAGES * NUM_LANES;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Per-stage q selection, bit i = lane i, 1 selects q1
    localparam logic [3:0] QSEL_L2  = 4'b0011;
    localparam logic [3:0] QSEL_L1  = 4'b1010;
    localparam logic [3:0] QSEL_L0  = 4'b1100;
    localparam logic [3:0] QSEL_OUT = 4'b0101;

    // Nibble tables, entry i stored at bits [4i+3:4i]
    localparam logic [63:0] Q0_T0 = 64'h4ACE95B023F6D718;
    localparam logic [63:0] Q0_T1 = 64'hD9076A4F53218BCE;
    localparam logic [63:0] Q0_T2 = 64'h17423F8C09D6E5AB;
    localparam logic [63:0] Q0_T3 = 64'hAC5803B9E6214F7D;
    localparam logic [63:0] Q1_T0 = 64'h5CA04913E67FDB82;
    localparam logic [63:0] Q1_T1 = 64'h809F5AD673C4B2E1;
    localparam logic [63:0] Q1_T2 = 64'hF3B28DE0A96157C4;
    localparam logic [63:0] Q1_T3 = 64'hA802F746ED3C159B;

    // Look up one nibble of a packed 16-entry table
    function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] idx);
        return tbl[{idx, 2'b00} +: 4];
    endfunction

    // Rotate a nibble right by one
    function automatic logic [3:0] ror4(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

    // Lane q-select mask for a given stage (stage-major order)
    function automatic logic [3:0] stage_qsel(input logic [1:0] stage);
        logic [3:0] m;
`ifdef TWOFISH_K3_EN
        case (stage)
            2'd0:    m = QSEL_L2;
            2'd1:    m = QSEL_L1;
            2'd2:    m = QSEL_L0;
            default: m = QSEL_OUT;
        endcase
`else
        case (stage)
            2'd0:    m = QSEL_L1;
            2'd1:    m = QSEL_L0;
            default: m = QSEL_OUT;
        endcase
`endif
        return m;
    endfunction

endpackage

// File: rtl/twofish_q_unit.sv
// Combinational Twofish q0/q1 byte permutation (nibble-split form).
module twofish_q_unit
    import twofish_pkg::*;
(
    input  logic       sel,
    input  logic [7:0] x,
    output logic [7:0] y_c
);

    logic [63:0] t0, t1, t2, t3;
    logic [3:0]  a0, b0, a1, b1, a2, b2, a3, b3;

    // Two rounds of mix + nibble substitution
    always_comb begin
        t0 = sel ? Q1_T0 : Q0_T0;
        t1 = sel ? Q1_T1 : Q0_T1;
        t2 = sel ? Q1_T2 : Q0_T2;
        t3 = sel ? Q1_T3 : Q0_T3;
        a0 = x[7:4];
        b0 = x[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
        a2 = nib(t0, a1);
        b2 = nib(t1, b1);
        a3 = a2 ^ b2;
        b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
        y_c = {nib(t3, b3), nib(t2, a3)};
    end

endmodule

// File: rtl/twofish_h_seq.sv
// Twofish h-function byte-path sequencer: one shared q unit, 4 lanes x N stages.
// TWOFISH_K3_EN: when defined, adds l2_in and a leading L2 stage (192-bit keys).
module twofish_h_seq
    import twofish_pkg::*;
#(
    parameter int unsigned PIPE_Q = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] l0_in,
    input  logic [31:0] l1_in,
`ifdef TWOFISH_K3_EN
    input  logic [31:0] l2_in,
`endif
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y_out
);

    state_t                 state;
    logic [3:0][7:0]        w;
    logic [3:0][7:0]        l0;
    logic [3:0][7:0]        l1;
`ifdef TWOFISH_K3_EN
    logic [3:0][7:0]        l2;
`endif
    logic [CNT_W-1:0]       cnt;
    logic                   phase;

    logic [1:0]             lane;
    logic [1:0]             stage;
    logic [3:0]             qmask;
    logic                   qsel;
    logic [7:0]             kbyte;
    logic [7:0]             q_c;
    logic [7:0]             step_val;
    logic                   step_wb;

    assign lane    = cnt[1:0];
    assign stage   = cnt[3:2];
    assign qmask   = stage_qsel(stage);
    assign qsel    = qmask[lane];
    assign step_wb = (PIPE_Q == 0) || phase;

    // Key byte XORed in at the current stage; last stage has none
    always_comb begin
        kbyte = 8'h00;
`ifdef TWOFISH_K3_EN
        case (stage)
            2'd0:    kbyte = l2[lane];
            2'd1:    kbyte = l1[lane];
            2'd2:    kbyte = l0[lane];
            default: kbyte = 8'h00;
        endcase
`else
        case (stage)
            2'd0:    kbyte = l1[lane];
            2'd1:    kbyte = l0[lane];
            default: kbyte = 8'h00;
        endcase
`endif
    end

    twofish_q_unit u_q (
        .sel (qsel),
        .x   (w[lane]),
        .y_c (q_c)
    );

    generate
        if (PIPE_Q != 0) begin : g_pipe
            logic [7:0] q_reg;
            // Capture lookup on the issue cycle; consumed on the writeback cycle
            always_ff @(posedge clk) begin
                if (rst) q_reg <= 8'h00;
                else     q_reg <= q_c;
            end
            assign step_val = q_reg ^ kbyte;
        end else begin : g_comb
            assign step_val = q_c ^ kbyte;
        end
    endgenerate

    // Control FSM, work/key registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= 32'h0;
            w         <= '0;
            l0        <= '0;
            l1        <= '0;
`ifdef TWOFISH_K3_EN
            l2        <= '0;
`endif
            cnt       <= '0;
            phase     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        w     <= x_in;
                        l0    <= l0_in;
                        l1    <= l1_in;
`ifdef TWOFISH_K3_EN
                        l2    <= l2_in;
`endif
                        cnt   <= '0;
                        phase <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(NUM_STEPS)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        y_out     <= w;
                    end else if (step_wb) begin
                        w[lane] <= step_val;
                        cnt     <= cnt + CNT_W'(1);
                        phase   <= 1'b0;
                    end else begin
                        phase <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twofish_h_seq.sv
// Directed self-checking bench for twofish_h_seq and its q unit.
// Honors TWOFISH_K3_EN (adds l2_in and the leading L2 stage).
module tb_twofish_h_seq;

    localparam int unsigned PIPE_Q   = 0;
`ifdef TWOFISH_K3_EN
    localparam bit          K3       = 1'b1;
`else
    localparam bit          K3       = 1'b0;
`endif
    localparam int unsigned STEP_CYC = (PIPE_Q != 0) ? 2 : 1;
    localparam int unsigned STEPS    = K3 ? 16 : 12;
    localparam int unsigned LAT      = STEP_CYC * STEPS + 1;
    localparam int unsigned BUDGET   = LAT + 20;

    // Reference nibble tables in natural order: T[q][table][index]
    localparam logic [3:0] T [2][4][16] = '{
        '{ '{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4},
           '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD},
           '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1},
           '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA} },
        '{ '{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5},
           '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8},
           '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF},
           '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA} }
    };

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x_in, l0_in, l1_in;
`ifdef TWOFISH_K3_EN
    logic [31:0] l2_in;
`endif
    logic        busy, out_valid, out_ready;
    logic [31:0] y_out;

    logic        qs;
    logic [7:0]  qx, qy;

    int n_tests;
    int n_fail;

    twofish_h_seq #(.PIPE_Q(PIPE_Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .l0_in     (l0_in),
        .l1_in     (l1_in),
`ifdef TWOFISH_K3_EN
        .l2_in     (l2_in),
`endif
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out)
    );

    twofish_q_unit u_qchk (
        .sel (qs),
        .x   (qx),
        .y_c (qy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mq(input int s, input logic [7:0] v);
        logic [3:0] a, b, a1, b1, a2, b2, a3, b3;
        a  = v[7:4];
        b  = v[3:0];
        a1 = a ^ b;
        b1 = a ^ ((b >> 1) | (b << 3)) ^ (a << 3);
        a2 = T[s][0][a1];
        b2 = T[s][1][b1];
        a3 = a2 ^ b2;
        b3 = a2 ^ ((b2 >> 1) | (b2 << 3)) ^ (a2 << 3);
        return {T[s][3][b3], T[s][2][a3]};
    endfunction

    function automatic logic [31:0] h_model(input logic [31:0] x, k0, k1, k2);
        logic [7:0] v0, v1, v2, v3;
        v0 = x[7:0]; v1 = x[15:8]; v2 = x[23:16]; v3 = x[31:24];
        if (K3) begin
            v0 = mq(1, v0) ^ k2[7:0];
            v1 = mq(1, v1) ^ k2[15:8];
            v2 = mq(0, v2) ^ k2[23:16];
            v3 = mq(0, v3) ^ k2[31:24];
        end
        v0 = mq(1, mq(0, mq(0, v0) ^ k1[7:0])   ^ k0[7:0]);
        v1 = mq(0, mq(0, mq(1, v1) ^ k1[15:8])  ^ k0[15:8]);
        v2 = mq(1, mq(1, mq(0, v2) ^ k1[23:16]) ^ k0[23:16]);
        v3 = mq(0, mq(1, mq(1, v3) ^ k1[31:24]) ^ k0[31:24]);
        return {v3, v2, v1, v0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] x, k0, k1, k2);
        x_in  = x;
        l0_in = k0;
        l1_in = k1;
`ifdef TWOFISH_K3_EN
        l2_in = k2;
`endif
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, wait for result
    task automatic run_op(input logic [31:0] x, k0, k1, k2, input bit hold,
                          output logic [31:0] exp, output int lat);
        exp = h_model(x, k0, k1, k2);
        drive(x, k0, k1, k2);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        drive(~x, ~k0, ~k1, ~k2);
        wait_valid(lat);
    endtask

    // Stall the consumer, then complete the handshake
    task automatic finish_op(input int stall, input logic [31:0] y);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", y_out, y);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("keep_y", y_out, y);
    endtask

    initial begin
        logic [31:0] exp, y;
        logic [31:0] vx, vk0, vk1, vk2;
        logic [255:0] seen;
        int lat;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        qs = 1'b0; qx = 8'h00;

        // q unit anchors from the published tables
        #1; check("q0_00", 32'(qy), 32'h0000_00A9);
        qx = 8'h01; #1; check("q0_01", 32'(qy), 32'h0000_0067);
        qs = 1'b1; qx = 8'h00; #1; check("q1_00", 32'(qy), 32'h0000_0075);
        qx = 8'h01; #1; check("q1_01", 32'(qy), 32'h0000_00F3);

        // Exhaustive q0/q1 against model, plus bijection
        for (int s = 0; s < 2; s++) begin
            seen = '0;
            for (int v = 0; v < 256; v++) begin
                qs = s[0];
                qx = v[7:0];
                #1;
                check("q_table", 32'(qy), 32'(mq(s, v[7:0])));
                seen[qy] = 1'b1;
            end
            check("q_bijection", 32'($countones(seen)), 32'd256);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_y", y_out, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-zero vector: latency and hand-derived result
        run_op(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, exp, lat);
        check("lat_zero", 32'(lat), 32'(LAT));
        check("busy_done", 32'(busy), 32'd1);
        check("y_zero_model", y_out, exp);
`ifndef TWOFISH_K3_EN
        check("y_zero_hand", y_out, 32'hA55B_1FB3);
`endif
        y = y_out;
        finish_op(3, y);

        // Directed key patterns
        run_op(32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h0F1E_2D3C, 1'b0, exp, lat);
        check("lat_d1", 32'(lat), 32'(LAT));
        check("y_d1", y_out, exp);
        finish_op(1, y_out);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, exp, lat);
        check("y_d2", y_out, exp);
        finish_op(0, y_out);
        run_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h3C3C_3C3C, 32'hFFFF_FFFF, 1'b0, exp, lat);
        check("y_d3", y_out, exp);
        finish_op(2, y_out);

        // Random vectors with random consumer stalls
        for (int i = 0; i < 20; i++) begin
            vx  = $urandom; vk0 = $urandom; vk1 = $urandom; vk2 = $urandom;
            run_op(vx, vk0, vk1, vk2, 1'b0, exp, lat);
            check("lat_rand", 32'(lat), 32'(LAT));
            check("y_rand", y_out, exp);
            finish_op(int'($urandom_range(0, 3)), y_out);
        end

        // Start held through an operation and across the DONE handshake
        run_op(32'h1357_9BDF, 32'h2468_ACE0, 32'hDEAD_BEEF, 32'hC0FF_EE00, 1'b1, exp, lat);
        check("lat_hold", 32'(lat), 32'(LAT));
        check("y_hold", y_out, exp);
        exp = h_model(32'hCAFE_F00D, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC);
        drive(32'hCAFE_F00D, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_start_ignored", 32'(busy), 32'd0);
        check("hs_valid_drop", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_next", 32'(busy), 32'd1);
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        wait_valid(lat);
        check("lat_next", 32'(lat), 32'(LAT));
        check("y_next", y_out, exp);
        finish_op(0, y_out);

        // Reset in the middle of RUN (cnt = 6)
        drive(32'h7766_5544, 32'h0102_0304, 32'hF0E0_D0C0, 32'h0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6 * STEP_CYC) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_y", y_out, 32'h0);
        run_op(32'h7766_5544, 32'h0102_0304, 32'hF0E0_D0C0, 32'h0, 1'b0, exp, lat);
        check("lat_fresh", 32'(lat), 32'(LAT));
        check("y_fresh", y_out, exp);
        finish_op(1, y_out);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
